uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated write FIFO, on-chip bit-period divider, and run-time frame configuration. It is the next-generation TX path of the UART subsystem. It accepts parallel words from the system side in single-cycle strobes and buffers up to `2**ADDR_W` words. It serialises them back-to-back with configurable width, parity and stop-bit count. The whole block runs on one oversampled clock.

---
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side handshake (p_data/d_valid in, fifo_full/fifo_count back) for uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_WIDTH-1:0] p_data;
  logic d_valid;
  logic fifo_full;
  logic [ADDR_W:0] fifo_count;
  modport master(output p_data, d_valid, input fifo_full, fifo_count);
  modport slave(input p_data, d_valid, output fifo_full, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with write FIFO, bit-period divider and per-frame latched config
//   clk, rest       : rising-edge clock, asynchronous active-low reset
//   wr (slave)      : p_data/d_valid write strobe in, fifo_full/fifo_count status out
//   prescale        : bit period in clk cycles, 0 behaves as 1
//   par_en, par_typ : parity enable, 0 even / 1 odd
//   stop2           : two stop bits when set
//   tx_out, busy    : registered serial line (idle high) and frame-on-line flag
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W = 3,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rest,
  uart_tx_fifo_if.slave         wr,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0] cnt_q;
  logic [PRESCALE_W-1:0] p_q, p_d, tim_q, tim_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic tx_q, tx_d, busy_q, busy_d;
  logic push, pop, tick, last_stop, empty;
  assign empty = cnt_q == '0;
  assign push = wr.d_valid && !cnt_q[ADDR_W];
  assign tick = tim_q == p_q - 1'b1;
  // idx_q doubles as the stop-bit counter, so the second stop bit is idx_q[0]
  assign last_stop = state_q == STOP && tick && (!stop2_q || idx_q[0]);
  assign pop = !empty && (state_q == IDLE || last_stop);
  assign wr.fifo_full = cnt_q[ADDR_W];
  assign wr.fifo_count = cnt_q;
  assign tx_out = tx_q;
  assign busy = busy_q;
  always_ff @(posedge clk)
    if (push) mem[wptr_q] <= wr.p_data;
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      p_q <= PRESCALE_W'(1);
      tim_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_q + ADDR_W'(push);
      rptr_q <= rptr_q + ADDR_W'(pop);
      cnt_q <= cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      p_q <= p_d;
      tim_q <= tim_d;
      idx_q <= idx_d;
      data_q <= data_d;
      par_en_q <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q <= stop2_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : START;
      START:   state_d = tick ? DATA : START;
      DATA:    state_d = tick && idx_q == IW'(DATA_WIDTH - 1) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = last_stop ? (empty ? IDLE : START) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    p_d = pop ? (prescale == '0 ? PRESCALE_W'(1) : prescale) : p_q;
    data_d = pop ? mem[rptr_q] : data_q;
    par_en_d = pop ? par_en : par_en_q;
    par_typ_d = pop ? par_typ : par_typ_q;
    stop2_d = pop ? stop2 : stop2_q;
    tim_d = (state_q == IDLE || tick) ? '0 : tim_q + 1'b1;
    idx_d = !tick ? idx_q :
            ((state_q == DATA && idx_q != IW'(DATA_WIDTH - 1)) || (state_q == STOP && !last_stop)) ? idx_q + 1'b1 : '0;
  end
  // outputs are registered from next-state values so they line up with state_q
  always_comb begin
    busy_d = state_d != IDLE;
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA ? data_d[idx_d] :
           state_d == PARITY ? ^data_d ^ par_typ_d : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scenarios for uart_tx_fifo checked against a queue-based line model
module tb_uart_tx_fifo;
  localparam int DW = 8, AW = 3, PW = 6, DEPTH = 1 << AW;
  logic clk = 0, rest = 1;
  logic [PW-1:0] prescale = 4;
  logic par_en = 0, par_typ = 0, stop2 = 0;
  logic tx_out, busy;
  int n_vec = 0, n_err = 0;
  logic [DW-1:0] fifo_m[$], sent_m[$];
  bit line_m[$];
  uart_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) wr();
  uart_tx_fifo #(.DATA_WIDTH(DW), .ADDR_W(AW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rest(rest), .wr(wr), .prescale(prescale), .par_en(par_en),
    .par_typ(par_typ), .stop2(stop2), .tx_out(tx_out), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [AW+3:0] exp_vec();
    return {line_m.size() != 0 ? line_m[0] : 1'b1, line_m.size() != 0, fifo_m.size() == DEPTH, (AW+1)'(fifo_m.size())};
  endfunction
  function automatic logic [AW+3:0] obs_vec();
    return {tx_out, busy, wr.fifo_full, wr.fifo_count};
  endfunction
  // model: line_m holds the remaining per-cycle line levels of the current frame
  task automatic step();
    logic [DW-1:0] w;
    int p;
    bit do_push, do_pop;
    @(posedge clk);
    if (!rest) begin
      fifo_m.delete();
      line_m.delete();
    end else begin
      do_push = wr.d_valid && fifo_m.size() < DEPTH;
      do_pop = line_m.size() <= 1 && fifo_m.size() != 0;
      if (do_pop) begin
        w = fifo_m.pop_front();
        sent_m.push_back(w);
        line_m.delete();
        p = prescale == 0 ? 1 : int'(prescale);
        repeat (p) line_m.push_back(1'b0);
        for (int b = 0; b < DW; b++) repeat (p) line_m.push_back(w[b]);
        if (par_en) repeat (p) line_m.push_back(($countones(w) % 2 == 1) ^ par_typ);
        repeat (p * (1 + int'(stop2))) line_m.push_back(1'b1);
      end else if (line_m.size() != 0) void'(line_m.pop_front());
      if (do_push) fifo_m.push_back(wr.p_data);
    end
    #1;
  endtask
  task automatic test_reset();
    #2 rest = 0;
    #1 n_vec++;
    if (obs_vec() !== {1'b1, 1'b0, 1'b0, (AW+1)'(0)}) begin n_err++; $display("FAIL reset_async got %b exp %b", obs_vec(), {1'b1, 1'b0, 1'b0, (AW+1)'(0)}); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) rest = 1;
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL reset c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
    end
  endtask
  task automatic test_single_frame();
    int nb = 0;
    bit done = 0;
    prescale = 4; par_en = 1; par_typ = 0; stop2 = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      wr.d_valid = c == 0; wr.p_data = 8'hA5;
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL single c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
      nb += int'(busy);
      done = c > 1 && !busy;
    end
    n_vec++;
    if (nb != 44) begin n_err++; $display("FAIL single_busy got %0d exp 44", nb); end
  endtask
  task automatic test_odd_two_stop();
    int nb = 0;
    bit done = 0;
    prescale = 1; par_en = 1; par_typ = 1; stop2 = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      wr.d_valid = c == 0; wr.p_data = 8'h00;
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL odd2 c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
      nb += int'(busy);
      done = c > 1 && !busy;
    end
    n_vec++;
    if (nb != 12) begin n_err++; $display("FAIL odd2_busy got %0d exp 12", nb); end
  endtask
  task automatic test_fifo_overflow();
    int peak = 0;
    bit full_seen = 0, done = 0;
    prescale = PW'($urandom_range(1, 3)); par_en = 1'($urandom); par_typ = 1'($urandom); stop2 = 1'($urandom);
    sent_m.delete();
    for (int c = 0; c < 500 && !done; c++) begin
      wr.d_valid = c < 10; wr.p_data = DW'(c + 1);
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL fill c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
      if (int'(wr.fifo_count) > peak) peak = int'(wr.fifo_count);
      full_seen |= wr.fifo_full === 1'b1;
      done = c > 12 && !busy && wr.fifo_count == 0;
    end
    n_vec++;
    if (peak != 8 || !full_seen) begin n_err++; $display("FAIL fill_peak got %0d/%0b exp 8/1", peak, full_seen); end
    n_vec++;
    if (sent_m.size() != 9) begin n_err++; $display("FAIL fill_words got %0d exp 9", sent_m.size()); end
    for (int i = 0; i < sent_m.size(); i++) begin
      n_vec++;
      if (sent_m[i] != DW'(i + 1)) begin n_err++; $display("FAIL fill_order i=%0d got %h exp %h", i, sent_m[i], DW'(i + 1)); end
    end
  endtask
  task automatic test_back_to_back();
    int nb = 0, falls = 0;
    bit prev = 0, done = 0;
    prescale = 2; par_en = 0; stop2 = 0; par_typ = 1'($urandom);
    for (int c = 0; c < 200 && !done; c++) begin
      wr.d_valid = c < 3; wr.p_data = DW'($urandom);
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL b2b c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
      nb += int'(busy);
      falls += int'(prev && !busy);
      prev = busy;
      done = c > 3 && !busy;
    end
    n_vec++;
    if (nb != 60 || falls != 1) begin n_err++; $display("FAIL b2b_busy got %0d/%0d exp 60/1", nb, falls); end
  endtask
  task automatic test_config_change();
    int nb = 0;
    bit done = 0;
    prescale = 3; par_en = 0; stop2 = 0; par_typ = 1'($urandom);
    for (int c = 0; c < 200 && !done; c++) begin
      wr.d_valid = c < 2; wr.p_data = DW'($urandom);
      if (c == 10) begin prescale = 2; par_en = 1; stop2 = 1; end
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL cfg c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
      nb += int'(busy);
      done = c > 2 && !busy;
    end
    n_vec++;
    if (nb != 54) begin n_err++; $display("FAIL cfg_busy got %0d exp 54", nb); end
  endtask
  task automatic test_reset_mid();
    int nb_post = 0;
    bit seen = 0;
    prescale = 4; par_en = 1'($urandom); par_typ = 1'($urandom); stop2 = 0;
    for (int c = 0; c < 120; c++) begin
      wr.d_valid = c < 3 || c == 60; wr.p_data = DW'($urandom);
      if (c == 14) rest = 1;
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL rmid c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
      if (c == 12) begin
        rest = 0;
        #1 n_vec++;
        if (obs_vec() !== {1'b1, 1'b0, 1'b0, (AW+1)'(0)}) begin n_err++; $display("FAIL rmid_async got %b exp %b", obs_vec(), {1'b1, 1'b0, 1'b0, (AW+1)'(0)}); end
      end
      if (c >= 14 && c <= 60) nb_post += int'(busy);
      if (c > 60) seen |= busy === 1'b1;
    end
    n_vec++;
    if (nb_post != 0 || !seen) begin n_err++; $display("FAIL rmid_post got %0d/%0b exp 0/1", nb_post, seen); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      wr.d_valid = $urandom_range(0, 3) == 0; wr.p_data = DW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        prescale = PW'($urandom_range(0, 3)); par_en = 1'($urandom); par_typ = 1'($urandom); stop2 = 1'($urandom);
      end
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin n_err++; $display("FAIL rand c=%0d got %b exp %b", c, obs_vec(), exp_vec()); end
    end
  endtask
  initial begin
    wr.d_valid = 0;
    wr.p_data = '0;
    test_reset();
    test_single_frame();
    test_odd_two_stop();
    test_fifo_overflow();
    test_back_to_back();
    test_config_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
